// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/LSU) arbiter onto one shared req/gnt/rvalid memory port,
// with an in-order ID FIFO that steers each response back to its owner.
// Macros: ARB_ROUND_ROBIN_EN selects round-robin on conflict (default: data beats instr);
//         ARB_SPURIOUS_RVALID_CHECK enables the simulation check for rvalid with nothing outstanding.
module mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH      = 64,
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,

   input  logic                    instr_req_i,
   input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
   output logic                    instr_gnt_o,
   output logic                    instr_rvalid_o,
   output logic [DATA_WIDTH-1:0]   instr_rdata_o,

   input  logic                    data_req_i,
   input  logic [ADDR_WIDTH-1:0]   data_addr_i,
   input  logic                    data_we_i,
   input  logic [DATA_WIDTH/8-1:0] data_be_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   output logic [DATA_WIDTH-1:0]   data_rdata_o,

   output logic                    mem_req_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic                    mem_we_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic                    mem_gnt_i,
   input  logic                    mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic                       win_valid;
   logic                       win_data;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       handshake;
   logic                       pop;
   logic                       head_id;

   logic [MAX_OUTSTANDING-1:0] id_fifo_q;
   logic [PTR_W-1:0]           wr_ptr_q;
   logic [PTR_W-1:0]           rd_ptr_q;
   logic [CNT_W-1:0]           count_q;

   assign win_valid = instr_req_i | data_req_i;

`ifdef ARB_ROUND_ROBIN_EN
   // last_q holds the previous winner ID; reset to data so instr wins the first tie
   logic last_q;

   assign win_data = data_req_i & (~instr_req_i | ~last_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= 1'b1;
      end else if (handshake) begin
         last_q <= win_data;
      end
   end
`else
   assign win_data = data_req_i;
`endif

   assign fifo_full  = (count_q == CNT_MAX);
   assign fifo_empty = (count_q == '0);

   // Full blocks the request for the whole cycle, even when a response frees a slot
   assign mem_req_o   = rst_ni & win_valid & ~fifo_full;
   assign handshake   = mem_req_o & mem_gnt_i;
   assign instr_gnt_o = handshake & ~win_data;
   assign data_gnt_o  = handshake & win_data;

   always_comb begin
      mem_addr_o  = instr_addr_i;
      mem_we_o    = 1'b0;
      mem_be_o    = '1;
      mem_wdata_o = '0;
      if (win_data) begin
         mem_addr_o  = data_addr_i;
         mem_we_o    = data_we_i;
         mem_be_o    = data_be_i;
         mem_wdata_o = data_wdata_i;
      end
   end

   // Responses with nothing outstanding are dropped rather than popping an empty FIFO
   assign pop            = rst_ni & mem_rvalid_i & ~fifo_empty;
   assign head_id        = id_fifo_q[rd_ptr_q];
   assign instr_rvalid_o = pop & ~head_id;
   assign data_rvalid_o  = pop & head_id;
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         id_fifo_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         if (handshake) begin
            id_fifo_q[wr_ptr_q] <= win_data;
            wr_ptr_q            <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({handshake, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef ARB_SPURIOUS_RVALID_CHECK
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(mem_rvalid_i && fifo_empty))
            else $error("mem_port_arbiter: mem_rvalid_i with no outstanding access");
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: owner/data expectations are queued at each
// predicted handshake and compared when the bench's memory returns the response.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam int unsigned BW = DW / 8;
   localparam int unsigned MAXO = 4;

   localparam logic [AW-1:0] IADDR  = 64'h0000_0000_8000_0000;
   localparam logic [AW-1:0] DADDR  = 64'h0000_0000_1000_0040;
   localparam logic [BW-1:0] DBE    = 8'h0F;
   localparam logic [DW-1:0] DWDATA = 64'h1122_3344_5566_7788;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b1;
   logic          instr_req_i = 1'b0;
   logic [AW-1:0] instr_addr_i = '0;
   logic          instr_gnt_o, instr_rvalid_o;
   logic [DW-1:0] instr_rdata_o;
   logic          data_req_i = 1'b0;
   logic [AW-1:0] data_addr_i = '0;
   logic          data_we_i = 1'b0;
   logic [BW-1:0] data_be_i = '0;
   logic [DW-1:0] data_wdata_i = '0;
   logic          data_gnt_o, data_rvalid_o;
   logic [DW-1:0] data_rdata_o;
   logic          mem_req_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [BW-1:0] mem_be_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_gnt_i = 1'b0;
   logic          mem_rvalid_i = 1'b0;
   logic [DW-1:0] mem_rdata_i = '0;

   typedef struct packed {
      logic          owner;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   logic m_last = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk_i = ~clk_i;

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   function automatic logic exp_winner(input logic ir, input logic dr);
`ifdef ARB_ROUND_ROBIN_EN
      if (ir && dr) return ~m_last;
      return dr;
`else
      return dr;
`endif
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      instr_req_i  = 1'b0;
      data_req_i   = 1'b0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      instr_addr_i = IADDR;
      data_addr_i  = DADDR;
      data_we_i    = 1'b1;
      data_be_i    = DBE;
      data_wdata_i = DWDATA;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      exp_q.delete();
      m_last = 1'b1;
   endtask

   task automatic test_drain_responses();
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         instr_req_i  = 1'b0;
         data_req_i   = 1'b0;
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = e.data;
         #4;
         checks++;
         if ({instr_rvalid_o, data_rvalid_o} !== {~e.owner, e.owner}) begin
            errors++;
            $display("FAIL resp_route: got i/d rvalid=%b expected %b", {instr_rvalid_o, data_rvalid_o}, {~e.owner, e.owner});
         end
         checks++;
         if ((e.owner ? data_rdata_o : instr_rdata_o) !== e.data) begin
            errors++;
            $display("FAIL resp_data: got %h expected %h", e.owner ? data_rdata_o : instr_rdata_o, e.data);
         end
         tick();
      end
      mem_rvalid_i = 1'b0;
   endtask

   task automatic test_reset();
      logic w;
      rst_ni = 1'b1;
      #2;
      rst_ni       = 1'b0;
      idle_inputs();
      instr_req_i  = 1'b1;
      data_req_i   = 1'b1;
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'hA5A5_0000_5A5A_FFFF;
      #2;
      w = exp_winner(1'b1, 1'b1);
      checks++;
      if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_forced: got %b expected 00000", {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o});
      end
      checks++;
      if (mem_addr_o !== (w ? DADDR : IADDR) || data_rdata_o !== 64'hA5A5_0000_5A5A_FFFF) begin
         errors++;
         $display("FAIL reset_mux: got addr=%h rdata=%h expected addr=%h rdata=%h", mem_addr_o, data_rdata_o, w ? DADDR : IADDR, 64'hA5A5_0000_5A5A_FFFF);
      end
      idle_inputs();
      tick();
      tick();
      rst_ni = 1'b1;
   endtask

   task automatic test_isolated_fetch();
      idle_inputs();
      instr_req_i  = 1'b1;
      instr_addr_i = 64'h0000_0000_8000_0000;
      mem_gnt_i    = 1'b1;
      #4;
      checks++;
      if ({mem_req_o, instr_gnt_o, data_gnt_o} !== 3'b110) begin
         errors++;
         $display("FAIL fetch_gnt: got req/ignt/dgnt=%b expected 110", {mem_req_o, instr_gnt_o, data_gnt_o});
      end
      checks++;
      if (mem_addr_o !== 64'h0000_0000_8000_0000 || mem_we_o !== 1'b0 || mem_be_o !== 8'hFF || mem_wdata_o !== '0) begin
         errors++;
         $display("FAIL fetch_mux: got addr=%h we=%b be=%h wdata=%h expected 80000000/0/ff/0", mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
      end
      exp_q.push_back('{owner: 1'b0, data: 64'h0000_0000_DEAD_BEEF});
      m_last = 1'b0;
      tick();
      idle_inputs();
      test_drain_responses();
   endtask

   task automatic test_conflict();
`ifdef ARB_ROUND_ROBIN_EN
      localparam int N = 4;
`else
      localparam int N = 3;
`endif
      logic w;
      do_reset();
      for (int i = 0; i < N; i++) begin
         idle_inputs();
         instr_req_i = 1'b1;
         data_req_i  = 1'b1;
         mem_gnt_i   = 1'b1;
         #4;
         w = exp_winner(1'b1, 1'b1);
         checks++;
         if ({instr_gnt_o, data_gnt_o} !== {~w, w}) begin
            errors++;
            $display("FAIL conflict_gnt%0d: got i/d gnt=%b expected %b", i, {instr_gnt_o, data_gnt_o}, {~w, w});
         end
         checks++;
         if (mem_addr_o !== (w ? DADDR : IADDR) || mem_we_o !== w || mem_be_o !== (w ? DBE : 8'hFF)
             || mem_wdata_o !== (w ? DWDATA : 64'h0)) begin
            errors++;
            $display("FAIL conflict_mux%0d: got addr=%h we=%b be=%h wdata=%h for winner %b", i, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, w);
         end
         exp_q.push_back('{owner: w, data: 64'hC0DE_0000_0000_0000 + 64'(i)});
         m_last = w;
         tick();
      end
      idle_inputs();
      test_drain_responses();
   endtask

   task automatic test_full_fifo();
      exp_t e;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         idle_inputs();
         instr_req_i = 1'b1;
         mem_gnt_i   = 1'b1;
         #4;
         checks++;
         if ({mem_req_o, instr_gnt_o} !== 2'b11) begin
            errors++;
            $display("FAIL fill%0d: got req/gnt=%b expected 11", i, {mem_req_o, instr_gnt_o});
         end
         exp_q.push_back('{owner: 1'b0, data: 64'hF111_0000_0000_0000 + 64'(i)});
         m_last = 1'b0;
         tick();
      end
      #4;
      checks++;
      if ({mem_req_o, instr_gnt_o} !== 2'b00) begin
         errors++;
         $display("FAIL full_block: got req/gnt=%b expected 00", {mem_req_o, instr_gnt_o});
      end
      tick();
      e = exp_q.pop_front();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = e.data;
      #4;
      checks++;
      if ({mem_req_o, instr_rvalid_o, data_rvalid_o} !== 3'b010 || instr_rdata_o !== e.data) begin
         errors++;
         $display("FAIL full_pop: got req/irv/drv=%b rdata=%h expected 010 rdata=%h", {mem_req_o, instr_rvalid_o, data_rvalid_o}, instr_rdata_o, e.data);
      end
      tick();
      mem_rvalid_i = 1'b0;
      #4;
      checks++;
      if ({mem_req_o, instr_gnt_o} !== 2'b11) begin
         errors++;
         $display("FAIL after_pop_req: got req/gnt=%b expected 11", {mem_req_o, instr_gnt_o});
      end
      exp_q.push_back('{owner: 1'b0, data: 64'hF111_0000_0000_0004});
      tick();
      idle_inputs();
      test_drain_responses();
   endtask

   task automatic test_push_pop();
      exp_t e;
      do_reset();
      idle_inputs();
      data_req_i = 1'b1;
      mem_gnt_i  = 1'b1;
      exp_q.push_back('{owner: 1'b1, data: 64'h0000_0000_0000_0A01});
      m_last = 1'b1;
      tick();
      idle_inputs();
      instr_req_i = 1'b1;
      mem_gnt_i   = 1'b1;
      exp_q.push_back('{owner: 1'b0, data: 64'h0000_0000_0000_0A02});
      m_last = 1'b0;
      tick();
      e = exp_q.pop_front();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = e.data;
      #4;
      checks++;
      if ({instr_gnt_o, instr_rvalid_o, data_rvalid_o} !== {1'b1, ~e.owner, e.owner} || data_rdata_o !== e.data) begin
         errors++;
         $display("FAIL push_pop: got gnt/irv/drv=%b rdata=%h expected %b rdata=%h", {instr_gnt_o, instr_rvalid_o, data_rvalid_o}, data_rdata_o, {1'b1, ~e.owner, e.owner}, e.data);
      end
      exp_q.push_back('{owner: 1'b0, data: 64'h0000_0000_0000_0A03});
      tick();
      mem_rvalid_i = 1'b0;
      instr_req_i  = 1'b0;
      data_req_i   = 1'b1;
      #4;
      checks++;
      if (data_gnt_o !== 1'b1) begin
         errors++;
         $display("FAIL pp_third: got data_gnt=%b expected 1", data_gnt_o);
      end
      exp_q.push_back('{owner: 1'b1, data: 64'h0000_0000_0000_0A04});
      m_last = 1'b1;
      tick();
      data_req_i  = 1'b0;
      instr_req_i = 1'b1;
      #4;
      checks++;
      if (instr_gnt_o !== 1'b1) begin
         errors++;
         $display("FAIL pp_fourth: got instr_gnt=%b expected 1", instr_gnt_o);
      end
      exp_q.push_back('{owner: 1'b0, data: 64'h0000_0000_0000_0A05});
      m_last = 1'b0;
      tick();
      #4;
      checks++;
      if (mem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL pp_full: got mem_req=%b expected 0", mem_req_o);
      end
      tick();
      idle_inputs();
      test_drain_responses();
   endtask

   task automatic test_spurious();
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = 64'hBAD0_0000_0000_0000 + 64'(i);
         #4;
         checks++;
         if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
            errors++;
            $display("FAIL spurious%0d: got i/d rvalid=%b expected 00", i, {instr_rvalid_o, data_rvalid_o});
         end
         tick();
      end
      mem_rvalid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         instr_req_i = (i % 2) == 0;
         data_req_i  = (i % 2) == 1;
         mem_gnt_i   = 1'b1;
         #4;
         checks++;
         if (mem_req_o !== (i < 4)) begin
            errors++;
            $display("FAIL spur_count%0d: got mem_req=%b expected %b", i, mem_req_o, i < 4);
         end
         if (i < 4) begin
            exp_q.push_back('{owner: data_req_i, data: 64'h5000_0000_0000_0000 + 64'(i)});
            m_last = data_req_i;
         end
         tick();
      end
      idle_inputs();
      test_drain_responses();
   endtask

   task automatic test_reset_midop();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         idle_inputs();
         data_req_i  = (i != 1);
         instr_req_i = (i == 1);
         mem_gnt_i   = 1'b1;
         tick();
      end
      rst_ni       = 1'b0;
      instr_req_i  = 1'b1;
      data_req_i   = 1'b1;
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = 1'b1;
      #4;
      checks++;
      if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 5'b0) begin
         errors++;
         $display("FAIL midop_reset: got %b expected 00000", {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o});
      end
      tick();
      idle_inputs();
      rst_ni       = 1'b1;
      exp_q.delete();
      m_last       = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mem_rvalid_i = 1'b1;
         #4;
         checks++;
         if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
            errors++;
            $display("FAIL stale%0d: got i/d rvalid=%b expected 00", i, {instr_rvalid_o, data_rvalid_o});
         end
         tick();
      end
      mem_rvalid_i = 1'b0;
      data_req_i   = 1'b1;
      mem_gnt_i    = 1'b1;
      #4;
      checks++;
      if (data_gnt_o !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_gnt: got data_gnt=%b expected 1", data_gnt_o);
      end
      exp_q.push_back('{owner: 1'b1, data: 64'h7777_0000_0000_0001});
      m_last = 1'b1;
      tick();
      idle_inputs();
      test_drain_responses();
   endtask

   initial begin
      test_reset();
      tick();
      test_isolated_fetch();
      test_conflict();
      test_full_fifo();
      test_push_pop();
      test_spurious();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
